// File: rtl/rtype_issue_if.sv
// Handshake and issue-side signal bundle for the R-type issue queue.
// The master side feeds instructions and hold; the slave side issues.
interface rtype_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        hold;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  r3;
    logic [5:0]  ctrl;
    logic        out_valid;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    modport master (
        output in_valid, in_instr, hold,
        input  in_ready, r1, r2, r3, ctrl,
        input  out_valid, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, hold,
        output in_ready, r1, r2, r3, ctrl,
        output out_valid, illegal, illegal_cnt
    );
endinterface

// File: rtl/rtype_issue.sv
// R-type decode at push time, circular instruction queue, registered issue.
// Rejected instructions pulse illegal and bump a saturating counter.
module rtype_issue #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    rtype_issue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0]  CTRL_BUB = 6'b10_0000;
    localparam logic [20:0] BUBBLE = {15'd0, CTRL_BUB};
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [20:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [20:0]   out_q, out_d;
    logic          ov_q, ov_d;
    logic          ill_q, ill_d;
    logic [7:0]    icnt_q, icnt_d;

    logic       full, ready, hs, legal, push, pop;
    logic [5:0] dctrl;

    always_comb begin
        dctrl = CTRL_BUB;
        legal = 1'b0;
        if (bus.in_instr[31:26] == 6'b0) begin
            legal = 1'b1;
            case (bus.in_instr[5:0])
                6'b100000: dctrl = 6'b10_0010;
                6'b100010: dctrl = 6'b10_0110;
                6'b100100: dctrl = 6'b10_0000;
                6'b100101: dctrl = 6'b10_0001;
                6'b101010: dctrl = 6'b10_0111;
                6'b100111: dctrl = 6'b10_1100;
                default:   legal = 1'b0;
            endcase
        end
    end

    // Ready ignores a same-cycle pop so the full path never depends on hold.
    assign full  = (count_q == FULL_CNT);
    assign ready = !full && !rst;
    assign hs    = bus.in_valid && ready;
    assign push  = hs && legal;
    assign pop   = !bus.hold && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;
        ov_d    = ov_q;
        ill_d   = hs && !legal;
        icnt_d  = icnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (!bus.hold) begin
            if (pop) begin
                out_d  = mem_q[rptr_q];
                ov_d   = 1'b1;
                rptr_d = rptr_q + 1'b1;
            end else begin
                out_d = BUBBLE;
                ov_d  = 1'b0;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ill_d && (icnt_q != 8'hFF)) begin
            icnt_d = icnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {bus.in_instr[25:11], dctrl};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            out_q   <= BUBBLE;
            ov_q    <= 1'b0;
            ill_q   <= 1'b0;
            icnt_q  <= 8'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            ill_q   <= ill_d;
            icnt_q  <= icnt_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.r1          = out_q[20:16];
    assign bus.r2          = out_q[15:11];
    assign bus.r3          = out_q[10:6];
    assign bus.ctrl        = out_q[5:0];
    assign bus.out_valid   = ov_q;
    assign bus.illegal     = ill_q;
    assign bus.illegal_cnt = icnt_q;
endmodule

// File: tb/tb_rtype_issue.sv
// Randomized bench for rtype_issue against a queue-based reference model.
// Each scenario task drives stimulus and checks its own observations.
module tb_rtype_issue;
    localparam int DEPTH = 4;
    localparam logic [20:0] BUBBLE = 21'b10_0000;
    localparam logic [5:0] FN [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    localparam logic [5:0] CT [6] = '{6'b100010, 6'b100110, 6'b100000,
                                      6'b100001, 6'b100111, 6'b101100};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    rtype_issue_if bus ();

    rtype_issue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [20:0] m_q[$];
    logic [20:0] m_out;
    bit          m_ov;
    bit          m_ill;
    int          m_cnt;

    function automatic bit ref_decode(input logic [31:0] ins, output logic [20:0] e);
        e = BUBBLE;
        if (ins[31:26] != 6'd0) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ins[5:0] == FN[i]) begin
                e = {ins[25:11], CT[i]};
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom();
        r[31:26] = 6'd0;
        r[5:0] = FN[$urandom_range(0, 5)];
        return r;
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] r;
        logic [20:0] e;
        r = $urandom();
        if ($urandom_range(0, 1) == 1) begin
            r[31:26] = 6'($urandom_range(1, 63));
        end else begin
            r[31:26] = 6'd0;
            while (ref_decode(r, e)) r[5:0] = 6'($urandom_range(0, 63));
        end
        return r;
    endfunction

    function automatic logic [20:0] dut_out();
        return {bus.r1, bus.r2, bus.r3, bus.ctrl};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_out = BUBBLE;
        m_ov = 1'b0;
        m_ill = 1'b0;
        m_cnt = 0;
    endtask

    task automatic tick();
        int          had;
        bit          acc;
        bit          ok;
        bit          hld;
        logic [20:0] e;
        had = m_q.size();
        acc = bus.in_valid && (had < DEPTH);
        ok = ref_decode(bus.in_instr, e);
        hld = bus.hold;
        @(posedge clk);
        if (!hld) begin
            if (had > 0) begin
                m_out = m_q.pop_front();
                m_ov = 1'b1;
            end else begin
                m_out = BUBBLE;
                m_ov = 1'b0;
            end
        end
        m_ill = acc && !ok;
        if (m_ill && m_cnt < 255) m_cnt++;
        if (acc && ok) m_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        bus.in_instr = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b ov=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        n_cmp++;
        if (dut_out() !== BUBBLE || bus.illegal !== 1'b0 || bus.illegal_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_out: out=%h ill=%b cnt=%0d want %h 0 0",
                     dut_out(), bus.illegal, bus.illegal_cnt, BUBBLE);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0022_1820;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_no_bypass: ov=%b want 0", bus.out_valid);
        end
        tick();
        n_cmp++;
        if (dut_out() !== {5'd1, 5'd2, 5'd3, 6'b100010} || bus.out_valid !== 1'b1
            || dut_out() !== m_out) begin
            n_fail++;
            $display("FAIL add_issue: out=%h ov=%b want %h 1",
                     dut_out(), bus.out_valid, {5'd1, 5'd2, 5'd3, 6'b100010});
        end
        tick();
        n_cmp++;
        if (dut_out() !== BUBBLE || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_bubble: out=%h ov=%b want %h 0", dut_out(), bus.out_valid, BUBBLE);
        end
    endtask

    task automatic test_fill_hold();
        logic [20:0] exp [DEPTH];
        logic [20:0] e;
        do_reset();
        bus.hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = rand_legal();
            void'(ref_decode(bus.in_instr, e));
            exp[i] = e;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: ready=%b ov=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        bus.hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_cmp++;
            if (dut_out() !== exp[i] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: out=%h ov=%b rdy=%b want %h 1 1",
                         i, dut_out(), bus.out_valid, bus.in_ready, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h8C22_0000;
        tick();
        n_cmp++;
        if (bus.illegal !== 1'b1 || bus.illegal_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL lw_reject: ill=%b cnt=%0d want 1 1", bus.illegal, bus.illegal_cnt);
        end
        bus.in_instr = 32'h0043_2022;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.illegal !== 1'b0 || bus.illegal_cnt !== 8'd1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_accept: ill=%b cnt=%0d ov=%b want 0 1 0",
                     bus.illegal, bus.illegal_cnt, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.ctrl !== 6'b100110 || bus.r3 !== 5'd4 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_issue: ctrl=%b r3=%0d ov=%b want 100110 4 1",
                     bus.ctrl, bus.r3, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_only: ov=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_saturate();
        int bad = 0;
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in_instr = rand_illegal();
            tick();
            if (bus.illegal_cnt !== 8'(m_cnt) || bus.illegal !== 1'b1) bad++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_track: %0d cycles disagreed with model count", bad);
        end
        n_cmp++;
        if (bus.illegal_cnt !== 8'd255 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d ov=%b rdy=%b want 255 0 1",
                     bus.illegal_cnt, bus.out_valid, bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_empty: ov=%b ill=%b want 0 0", bus.out_valid, bus.illegal);
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_instr = rand_legal();
            tick();
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dut_out() !== BUBBLE) begin
            n_fail++;
            $display("FAIL async_rst: ov=%b rdy=%b out=%h want 0 0 %h",
                     bus.out_valid, bus.in_ready, dut_out(), BUBBLE);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL async_drained: %0d cycles issued after reset, want 0", bad);
        end
    endtask

    task automatic test_stream();
        int bad = 0;
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_instr = rand_legal();
            if (bus.in_ready !== 1'b1) bad++;
            tick();
            if (i >= 1 && (bus.out_valid !== 1'b1 || dut_out() !== m_out)) bad++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_random();
        int bad_rdy = 0;
        int bad_out = 0;
        int bad_ill = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid = ($urandom_range(0, 99) < 70);
            bus.hold = ($urandom_range(0, 99) < 35);
            bus.in_instr = ($urandom_range(0, 99) < 75) ? rand_legal() : rand_illegal();
            if (bus.in_ready !== (m_q.size() < DEPTH)) bad_rdy++;
            tick();
            if (dut_out() !== m_out || bus.out_valid !== m_ov) bad_out++;
            if (bus.illegal !== m_ill || bus.illegal_cnt !== 8'(m_cnt)) bad_ill++;
        end
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        n_cmp++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL rand_ready: %0d cycles wrong, want 0", bad_rdy);
        end
        n_cmp++;
        if (bad_out != 0) begin
            n_fail++;
            $display("FAIL rand_issue: %0d cycles wrong, want 0", bad_out);
        end
        n_cmp++;
        if (bad_ill != 0) begin
            n_fail++;
            $display("FAIL rand_illegal: %0d cycles wrong, want 0", bad_ill);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        bus.in_instr = '0;
        model_reset();
        test_reset();
        test_single_add();
        test_fill_hold();
        test_illegal();
        test_saturate();
        test_async_reset();
        test_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rtype_issue.md
RTYPE_ISSUE -- requirements
Module: rtype_issue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue depth in entries; the design SHALL support powers of two from 2 to 16.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  upstream offers in_instr this cycle.
REQ-005 Port in_ready  output  1  queue can accept; SHALL equal !full && !rst.
REQ-006 Port in_instr  input  32  MIPS-format instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-007 Port hold  input  1  downstream freeze; output register SHALL keep its value while high.
REQ-008 Port r1  output  5  source register A (rs), registered.
REQ-009 Port r2  output  5  source register B (rt), registered.
REQ-010 Port r3  output  5  destination register (rd), registered.
REQ-011 Port ctrl  output  6  reduced function bits: ctrl[5:4] ALU op, ctrl[3:0] ALU control, registered.
REQ-012 Port out_valid  output  1  r1/r2/r3/ctrl carry a real instruction this cycle.
REQ-013 Port illegal  output  1  one-cycle pulse when an accepted instruction is rejected.
REQ-014 Port illegal_cnt  output  8  saturating count of rejected instructions.

Function
REQ-015 A handshake SHALL occur when in_valid && in_ready at a rising edge; otherwise in_instr SHALL be ignored.
REQ-016 Each handshaken instruction SHALL be decoded at push time: opcode 000000 with a supported funct is legal; all others are illegal.
REQ-017 The supported funct-to-ctrl mapping SHALL be: 100000 add -> 10_0010; 100010 sub -> 10_0110; 100100 and -> 10_0000; 100101 or -> 10_0001; 101010 slt -> 10_0111; 100111 nor -> 10_1100.
REQ-018 A legal instruction SHALL be written into the queue as {rs, rt, rd, ctrl} (21 bits).
REQ-019 An illegal instruction SHALL NOT be queued; illegal SHALL pulse high the next cycle and illegal_cnt SHALL increment, saturating at 255.
REQ-020 The queue SHALL be a circular buffer with DEPTH entries, wrapping read/write pointers, and an occupancy count from 0 to DEPTH; full SHALL be count==DEPTH.
REQ-021 On each edge with hold low and count>0, the head entry SHALL be popped into the output register and out_valid SHALL be set to 1.
REQ-022 On each edge with hold low and count==0, the output register SHALL load a bubble (r1=r2=r3=0, ctrl=10_0000) and out_valid SHALL be set to 0.
REQ-023 On each edge with hold high, the output register, out_valid and the read pointer SHALL be unchanged; pushes SHALL still be accepted.
REQ-024 Latency: an instruction pushed into an empty queue at edge N SHALL appear on the outputs after edge N+1; there is no same-cycle bypass.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; when full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-026 Order SHALL be preserved: legal instructions issue strictly in arrival order, and illegal ones leave no gap.
REQ-027 The bubble SHALL target r3=0, so the downstream unconditional write-back only touches register 0.

Reset
REQ-028 While rst is high: pointers=0, count=0, outputs=bubble, out_valid=0, illegal=0, illegal_cnt=0, in_ready=0.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-030 in_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-031 Push add 0x00221820 into an empty queue, hold low -> one cycle later: r1=1, r2=2, r3=3, ctrl=100010, out_valid=1; the following cycle shows a bubble.
REQ-032 Hold high, push 4 legal instructions (DEPTH=4) -> in_ready=0 after the 4th; release hold -> the 4 instructions issue on 4 consecutive cycles in order, and in_ready=1 after the first pop.
REQ-033 Push lw 0x8C220000, then sub 0x00432022 -> illegal pulses once, illegal_cnt=1; only sub issues (ctrl=100110, r3=4).
REQ-034 Push 300 illegal instructions -> illegal_cnt stays at 255 and the queue stays empty.
REQ-035 Push 3 instructions, then assert rst asynchronously between edges -> out_valid=0 and in_ready=0 immediately; after release nothing issues.
REQ-036 Drive a continuous stream at one push per cycle with hold low -> in_ready stays 1 and out_valid=1 every cycle from the 2nd cycle onward.
